uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered 8N1 UART transmitter that drives the `tx` pin of the microcontroller. It sits directly downstream of the DMA UART engine and the peripheral controller's UART register. It accepts bytes through a one-cycle write strobe into an internal FIFO and serialises them back-to-back. It reports FIFO status, overflow and an end-of-transmission pulse so the DMA can stop feeding and raise its completion event.

## Interface

Parameters:
- `CLK_DIV`, default 434: clock cycles per bit (50 MHz / 115200). Legal range is ≥2.
- `FIFO_DEPTH`, default 16: FIFO depth in bytes. Must be a power of two, ≥2.
- `CW`, default `$clog2(FIFO_DEPTH)+1`: width of `count`.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `wr_en`  in  1: byte write strobe, one byte per asserted cycle.
- `wr_data`  in  8: byte to enqueue.
- `clr_ovf`  in  1: clears `ovf`.
- `full`  out  1: FIFO holds `FIFO_DEPTH` bytes.
- `empty`  out  1: FIFO holds 0 bytes.
- `count`  out  CW: number of bytes queued, excluding the byte in the shifter.
- `busy`  out  1: a frame is on the line (state is not IDLE).
- `ovf`  out  1: sticky flag, set when a write is attempted while `full`.
- `eot`  out  1: one-cycle pulse at the end of a stop bit when the FIFO is empty.
- `tx`  out  1: serial line, idle high.

## Operation

- **FIFO**
  - Circular buffer with read and write pointers of `log2(FIFO_DEPTH)` bits. Pointers wrap modulo depth.
  - `full`, `empty` and `count` are registered and reflect the state after the previous edge.
  - A write is accepted iff `wr_en && !full` at the edge. Acceptance is decided on pre-edge `full`, even if a pop happens at the same edge.
  - Rejected write: data is dropped and `ovf` is set.
  - Simultaneous accepted write and pop: `count` is unchanged and both pointers advance.
- **ovf**
  - Set has priority over `clr_ovf` in the same cycle.
  - Otherwise `clr_ovf` clears it.
- **Transmit FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If `!empty`, pop the FIFO head into the 8-bit shifter, load the bit counter with `CLK_DIV-1`, and go to START.
  - START: `tx=0` for `CLK_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `tx=shifter[0]`, LSB first. Each `CLK_DIV` cycles: shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: `tx=1` for `CLK_DIV` cycles. On the last cycle:
    - If `!empty`: pop, reload the shifter and go directly to START, with no idle gap.
    - Else: pulse `eot` and go to IDLE.
- **Baud counter:** counts down from `CLK_DIV-1` to 0. It reloads at every bit boundary and is held at `CLK_DIV-1` in IDLE.
- **tx:** driven from a register, so it has no glitches.
- **Reset (`rst_n`=0, any time including mid-frame), immediately and asynchronously:**
  - `tx=1`, state IDLE.
  - FIFO emptied: pointers 0, `count=0`, `empty=1`, `full=0`.
  - `busy=0`, `ovf=0`, `eot=0`.
  - Queued and in-flight bytes are discarded.

## Timing

- **Write to start bit:** with a byte written at edge N while IDLE and empty:
  - `empty` deasserts after edge N.
  - Pop and IDLE→START occur at edge N+1; `tx` falls after edge N+1.
- **Frame length:** exactly `10*CLK_DIV` cycles from `tx` falling to the end of the stop bit.
- **Back-to-back frames:** the next start bit follows the stop bit with zero extra cycles.
- **`eot`:** high for exactly the one cycle after the edge that ends the final stop bit. `busy` drops in that same cycle.
- **`count`:** decrements in the cycle the shifter loads, not when the frame finishes.
- **Throughput limit:** the writer may fill the FIFO faster than the line drains it. `full` is the backpressure signal; there is no ready/stall handshake beyond it.

## Test plan

- **Reset values:** assert `rst_n`=0 mid-DATA of a frame with 3 bytes queued → `tx`=1 asynchronously; `count`=0, `empty`=1, `busy`=0, `ovf`=0; no further frames after release.
- **Single byte:** `CLK_DIV`=4, write 0xA5 at edge N → `tx` falls after N+1. Line pattern per 4 cycles: 0,1,0,1,0,0,1,0,1,1. `eot` pulses once 40 cycles after the fall.
- **Burst:** `CLK_DIV`=4, write 0x00, 0xFF, 0x55 on consecutive cycles → three contiguous 40-cycle frames with no idle high between stop and start. A single `eot` follows the third stop bit. `count` goes 1, 2 → 1, 2 → 1 → 0.
- **Full/overflow:** `FIFO_DEPTH`=4, hold `tx` busy and write 6 bytes → `full`=1 after the 5th write (first byte is in the shifter). The 6th write is dropped and `ovf`=1. Pulse `clr_ovf` → `ovf`=0. Transmitted data equals bytes 1–5 in order.
- **Simultaneous edges:**
  - Write on the same edge the STOP state pops with `count`=1 → `count` stays 1 and the byte order is preserved.
  - Write while `full` on a pop edge → rejected, `ovf`=1.
  - `clr_ovf` on the same cycle as a rejected write → `ovf` stays 1.
- **Pointer wrap:** `FIFO_DEPTH`=4, stream 10 bytes 0x10–0x19 keeping `count`≤3 → serialised output is 0x10..0x19 in order, with no `ovf`.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// Buffered 8N1 UART transmitter. Bytes written with a one-cycle strobe go
// into a circular FIFO. They are serialised LSB first, with no idle gap
// between consecutive frames.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   wr_en    in   byte write strobe (one byte per asserted cycle)
//   wr_data  in   byte to enqueue
//   clr_ovf  in   clears the sticky overflow flag
//   full     out  FIFO holds FIFO_DEPTH bytes
//   empty    out  FIFO holds no bytes
//   count    out  bytes queued, not counting the byte in the shifter
//   busy     out  a frame is on the line
//   ovf      out  sticky: a write was attempted while full
//   eot      out  one-cycle pulse when the last stop bit ends with FIFO empty
//   tx       out  serial line, idle high, registered

module uart_tx_buffered #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          ovf,
  output logic          eot,
  output logic          tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shifter_q, shifter_d;
  logic          tx_q, tx_d, eot_q, eot_d;
  logic          push, pop;

  // FIFO bookkeeping. Acceptance is judged on the registered full flag, so a
  // write that coincides with a pop while full is still rejected.
  always_comb begin
    push     = wr_en && !full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    full_d  = (count_d == CW'(FIFO_DEPTH));
    empty_d = (count_d == '0);
    // A new overflow wins over a clear in the same cycle.
    ovf_d = ovf_q;
    if (wr_en && full_q) ovf_d = 1'b1;
    else if (clr_ovf)    ovf_d = 1'b0;
  end

  // Transmit FSM. The STOP state pops the next byte on its last cycle so
  // back-to-back frames have no idle gap. tx is derived from the next state
  // and registered, so the line never glitches.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shifter_d = shifter_q;
    eot_d     = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = BAUD_MAX;
        if (!empty_q) begin
          pop       = 1'b1;
          shifter_d = mem[rd_ptr_q];
          state_d   = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d    = BAUD_MAX;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d    = BAUD_MAX;
          shifter_d = shifter_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          baud_d = BAUD_MAX;
          if (!empty_q) begin
            pop       = 1'b1;
            shifter_d = mem[rd_ptr_q];
            state_d   = START;
          end else begin
            eot_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shifter_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Byte storage needs no reset: a location is only read after it is written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      baud_q    <= BAUD_MAX;
      bit_idx_q <= 3'd0;
      shifter_q <= 8'h00;
      tx_q      <= 1'b1;
      eot_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shifter_q <= shifter_d;
      tx_q      <= tx_d;
      eot_q     <= eot_d;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;
  assign busy  = (state_q != IDLE);
  assign ovf   = ovf_q;
  assign eot   = eot_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered with CLK_DIV=4 and FIFO_DEPTH=4.
// A line receiver decodes every frame independently of the DUT internals.
module tb_uart_tx_buffered;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_ovf = 1'b0;
  logic          full, empty, busy, ovf, eot, tx;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int eot_cnt = 0;
  int frame_errs = 0;
  logic [7:0] rx_bytes[$];
  int rx_starts[$];

  uart_tx_buffered #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .clr_ovf(clr_ovf), .full(full), .empty(empty), .count(count),
    .busy(busy), .ovf(ovf), .eot(eot), .tx(tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count eot pulses, sampled 1 time unit after each rising edge.
  always begin
    @(posedge clk); #1;
    if (eot === 1'b1) eot_cnt++;
  end

  // Line receiver: samples the middle of each bit and records bytes and the
  // cycle of each start bit.
  initial begin : receiver
    logic [7:0] b;
    b = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rst_n === 1'b1 && tx === 1'b0) begin
        rx_starts.push_back(cyc);
        repeat (2) begin @(posedge clk); #1; end
        if (tx !== 1'b0) frame_errs++;
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) begin @(posedge clk); #1; end
          b[i] = tx;
        end
        repeat (CLK_DIV) begin @(posedge clk); #1; end
        if (tx !== 1'b1) frame_errs++;
        @(posedge clk); #1;
        rx_bytes.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && empty) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    int lows;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({tx, busy, empty, full, count, ovf, eot} !== 9'b1_0_1_0_000_0_0) begin
      errors++;
      $display("[TB] FAIL reset_init: got %b expected %b",
               {tx, busy, empty, full, count, ovf, eot}, 9'b1_0_1_0_000_0_0);
    end
    rst_n = 1'b1;
    tick();
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'h11 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("[TB] FAIL reset_queued: got %0d expected 3", count);
    end
    repeat (15) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_midframe_busy: got %b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, busy, empty, full, count, ovf, eot} !== 9'b1_0_1_0_000_0_0) begin
      errors++;
      $display("[TB] FAIL reset_async: got %b expected %b",
               {tx, busy, empty, full, count, ovf, eot}, 9'b1_0_1_0_000_0_0);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("[TB] FAIL reset_no_frames: got %0d active cycles expected 0", lows);
    end
    rx_bytes.delete();
    rx_starts.delete();
    frame_errs = 0;
  endtask

  task automatic test_single_byte();
    int e0, bad;
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    e0 = eot_cnt;
    rx_bytes.delete();
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    checks++;
    if ({empty, count, tx} !== {1'b0, 3'd1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL single_write: got %b expected %b", {empty, count, tx}, {1'b0, 3'd1, 1'b1});
    end
    tick();
    checks++;
    if ({tx, busy, count} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("[TB] FAIL single_start: got %b expected %b", {tx, busy, count}, {1'b0, 1'b1, 3'd0});
    end
    bad = 0;
    for (int k = 1; k < 40; k++) begin
      tick();
      if (tx !== fr[k / CLK_DIV] || eot !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL single_pattern: got %0d wrong cycles expected 0", bad);
    end
    tick();
    checks++;
    if ({eot, busy, tx} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL single_eot: got %b expected 101", {eot, busy, tx});
    end
    tick();
    checks++;
    if (eot !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_eot_width: got %b expected 0", eot);
    end
    tick();
    checks++;
    if (eot_cnt - e0 !== 1 || rx_bytes.size() !== 1 || frame_errs !== 0) begin
      errors++;
      $display("[TB] FAIL single_summary: got eot=%0d bytes=%0d ferr=%0d expected 1 1 0",
               eot_cnt - e0, rx_bytes.size(), frame_errs);
    end else begin
      checks++;
      if (rx_bytes[0] !== 8'hA5) begin
        errors++;
        $display("[TB] FAIL single_data: got %h expected a5", rx_bytes[0]);
      end
    end
  endtask

  task automatic test_burst();
    int e0, s0;
    logic [23:0] got;
    e0 = eot_cnt;
    s0 = rx_starts.size();
    rx_bytes.delete();
    wr_en = 1'b1;
    wr_data = 8'h00; tick();
    checks++;
    if (count !== 3'd1) begin
      errors++; $display("[TB] FAIL burst_count0: got %0d expected 1", count);
    end
    wr_data = 8'hFF; tick();
    checks++;
    if ({count, tx} !== {3'd1, 1'b0}) begin
      errors++; $display("[TB] FAIL burst_count1: got %b expected %b", {count, tx}, {3'd1, 1'b0});
    end
    wr_data = 8'h55; tick();
    wr_en = 1'b0;
    checks++;
    if (count !== 3'd2) begin
      errors++; $display("[TB] FAIL burst_count2: got %0d expected 2", count);
    end
    repeat (39) tick();
    checks++;
    if ({tx, count} !== {1'b0, 3'd1}) begin
      errors++; $display("[TB] FAIL burst_frame2: got %b expected %b", {tx, count}, {1'b0, 3'd1});
    end
    repeat (40) tick();
    checks++;
    if ({tx, count, empty} !== {1'b0, 3'd0, 1'b1}) begin
      errors++; $display("[TB] FAIL burst_frame3: got %b expected %b", {tx, count, empty}, {1'b0, 3'd0, 1'b1});
    end
    repeat (40) tick();
    checks++;
    if ({eot, busy} !== 2'b10) begin
      errors++; $display("[TB] FAIL burst_eot: got %b expected 10", {eot, busy});
    end
    repeat (3) tick();
    got = (rx_bytes.size() == 3) ? {rx_bytes[0], rx_bytes[1], rx_bytes[2]} : 24'hxxxxxx;
    checks++;
    if (got !== 24'h00FF55 || frame_errs !== 0) begin
      errors++; $display("[TB] FAIL burst_data: got %h ferr=%0d expected 00ff55 ferr=0", got, frame_errs);
    end
    checks++;
    if (rx_starts.size() !== s0 + 3 || eot_cnt - e0 !== 1) begin
      errors++; $display("[TB] FAIL burst_frames: got starts=%0d eot=%0d expected 3 1",
                         rx_starts.size() - s0, eot_cnt - e0);
    end else begin
      checks++;
      if (rx_starts[s0 + 1] - rx_starts[s0] !== 40 || rx_starts[s0 + 2] - rx_starts[s0 + 1] !== 40) begin
        errors++; $display("[TB] FAIL burst_gap: got %0d %0d expected 40 40",
                           rx_starts[s0 + 1] - rx_starts[s0], rx_starts[s0 + 2] - rx_starts[s0 + 1]);
      end
    end
  endtask

  task automatic test_full_ovf();
    bit ok;
    logic [39:0] got;
    rx_bytes.delete();
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h31 + 8'(i);
      tick();
    end
    checks++;
    if ({full, count} !== {1'b1, 3'd4}) begin
      errors++; $display("[TB] FAIL full_after5: got %b expected %b", {full, count}, {1'b1, 3'd4});
    end
    wr_data = 8'h36; tick();
    wr_en = 1'b0;
    checks++;
    if ({ovf, full, count} !== {1'b1, 1'b1, 3'd4}) begin
      errors++; $display("[TB] FAIL ovf_set: got %b expected %b", {ovf, full, count}, {1'b1, 1'b1, 3'd4});
    end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", ovf);
    end
    repeat (34) tick();
    checks++;
    if ({full, ovf, tx} !== 3'b101) begin
      errors++; $display("[TB] FAIL full_before_pop: got %b expected 101", {full, ovf, tx});
    end
    wr_en = 1'b1; wr_data = 8'h37; clr_ovf = 1'b1;
    tick();
    wr_en = 1'b0; clr_ovf = 1'b0;
    checks++;
    if ({ovf, full, count, tx} !== {1'b1, 1'b0, 3'd3, 1'b0}) begin
      errors++; $display("[TB] FAIL ovf_on_pop: got %b expected %b",
                         {ovf, full, count, tx}, {1'b1, 1'b0, 3'd3, 1'b0});
    end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_clear2: got %b expected 0", ovf);
    end
    wait_idle(400, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL full_drain: got busy expected idle within 400 cycles");
    end
    got = (rx_bytes.size() == 5) ? {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3], rx_bytes[4]} : 40'hx;
    checks++;
    if (got !== 40'h3132333435 || frame_errs !== 0) begin
      errors++; $display("[TB] FAIL full_data: got %h ferr=%0d expected 3132333435 ferr=0", got, frame_errs);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int e0;
    logic [23:0] got;
    e0 = eot_cnt;
    rx_bytes.delete();
    wr_en = 1'b1; wr_data = 8'hC3; tick();
    wr_en = 1'b0; tick();
    wr_en = 1'b1; wr_data = 8'h3C; tick();
    wr_en = 1'b0;
    checks++;
    if (count !== 3'd1) begin
      errors++; $display("[TB] FAIL simul_count_pre: got %0d expected 1", count);
    end
    repeat (38) tick();
    checks++;
    if ({count, tx} !== {3'd1, 1'b1}) begin
      errors++; $display("[TB] FAIL simul_stop: got %b expected %b", {count, tx}, {3'd1, 1'b1});
    end
    wr_en = 1'b1; wr_data = 8'h81; tick();
    wr_en = 1'b0;
    checks++;
    if ({count, tx, ovf} !== {3'd1, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL simul_push_pop: got %b expected %b", {count, tx, ovf}, {3'd1, 1'b0, 1'b0});
    end
    wait_idle(300, ok);
    got = (rx_bytes.size() == 3) ? {rx_bytes[0], rx_bytes[1], rx_bytes[2]} : 24'hxxxxxx;
    checks++;
    if (!ok || got !== 24'hC33C81 || eot_cnt - e0 !== 1) begin
      errors++; $display("[TB] FAIL simul_order: got %h idle=%0d eot=%0d expected c33c81 1 1",
                         got, ok, eot_cnt - e0);
    end
  endtask

  task automatic test_pointer_wrap();
    bit ok;
    int max_count, bad;
    logic ovf_seen;
    rx_bytes.delete();
    max_count = 0;
    ovf_seen = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'h10 + 8'(i);
      tick();
      if (int'(count) > max_count) max_count = int'(count);
    end
    wr_en = 1'b0;
    for (int i = 4; i < 10; i++) begin
      for (int j = 0; j < 40; j++) begin
        tick();
        if (int'(count) > max_count) max_count = int'(count);
        if (ovf !== 1'b0) ovf_seen = 1'b1;
      end
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      tick();
      wr_en = 1'b0;
      if (int'(count) > max_count) max_count = int'(count);
    end
    wait_idle(400, ok);
    checks++;
    if (!ok || max_count > 3 || ovf_seen || ovf !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_flow: got idle=%0d maxcount=%0d ovf=%0d expected 1 <=3 0",
                         ok, max_count, ovf_seen);
    end
    bad = 0;
    if (rx_bytes.size() != 10) bad = 1;
    else for (int i = 0; i < 10; i++) if (rx_bytes[i] !== 8'h10 + 8'(i)) bad++;
    checks++;
    if (bad !== 0 || frame_errs !== 0) begin
      errors++; $display("[TB] FAIL wrap_data: got %0d bytes %0d bad ferr=%0d expected 10 bytes 0 bad 0",
                         rx_bytes.size(), bad, frame_errs);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_full_ovf();
    test_simultaneous();
    test_pointer_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
